// File: rtl/ysyx_22041207_mdu_sched.sv
// Multi-cycle MUL/DIV sequencer between the ALU and the iterative mul/div units.
// Resolves RV64 div-by-zero and overflow locally; watchdog aborts a hung unit.
module ysyx_22041207_mdu_sched #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic            in_word,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  output logic [XLEN-1:0] out_res,
  output logic            stall,
  output logic            err,
  output logic            mul_valid,
  input  logic            mul_ready,
  input  logic            mul_out_valid,
  output logic [XLEN-1:0] mul_a,
  output logic [XLEN-1:0] mul_b,
  input  logic [XLEN-1:0] mul_res,
  output logic            div_valid,
  input  logic            div_ready,
  input  logic            div_out_valid,
  output logic            div_signed,
  output logic [XLEN-1:0] div_a,
  output logic [XLEN-1:0] div_b,
  input  logic [XLEN-1:0] div_quot,
  input  logic [XLEN-1:0] div_rem,
  output logic            unit_flush
);

  localparam logic [2:0] OP_MUL  = 3'd0;
  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_DIVU = 3'd2;
  localparam logic [2:0] OP_REM  = 3'd3;
  localparam logic [2:0] OP_REMU = 3'd4;

  typedef enum logic [2:0] {
    IDLE, MUL_REQ, MUL_WAIT, DIV_REQ, DIV_WAIT, DONE
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q;
  logic              word_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic [XLEN-1:0]   out_res_q;
  logic              err_q, uflush_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              take, load, err_set, uflush_d;
  logic              busy_q, busy_d, wd_fire;
  logic              sgn, is_div, wsel;
  logic [XLEN-1:0]   a_ext, b_ext, smin, res_n, fin;

  assign sgn    = (in_op == OP_DIV) || (in_op == OP_REM);
  assign is_div = (in_op == OP_DIV) || (in_op == OP_DIVU);

  // W-form: signed ops sign-extend, unsigned ops zero-extend the low word
  always_comb begin
    a_ext = in_a;
    b_ext = in_b;
    if (in_word) begin
      a_ext = {{(XLEN-32){sgn & in_a[31]}}, in_a[31:0]};
      b_ext = {{(XLEN-32){sgn & in_b[31]}}, in_b[31:0]};
    end
  end

  assign smin = in_word ? {{(XLEN-31){1'b1}}, 31'b0}
                        : {1'b1, {(XLEN-1){1'b0}}};

  assign busy_q = (state_q == MUL_REQ) || (state_q == MUL_WAIT) ||
                  (state_q == DIV_REQ) || (state_q == DIV_WAIT);
  assign busy_d = (state_d == MUL_REQ) || (state_d == MUL_WAIT) ||
                  (state_d == DIV_REQ) || (state_d == DIV_WAIT);

  assign wd_fire = (TIMEOUT != 0) && busy_q &&
                   (cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    state_d  = state_q;
    take     = 1'b0;
    load     = 1'b0;
    err_set  = 1'b0;
    uflush_d = 1'b0;
    res_n    = '0;
    if (flush) begin
      state_d  = IDLE;
      uflush_d = busy_q;
    end else if (wd_fire) begin
      state_d  = DONE;
      load     = 1'b1;
      err_set  = 1'b1;
      uflush_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          take    = 1'b1;
          load    = 1'b1;
          state_d = DONE;
          if (in_op > OP_REMU) begin
            err_set = 1'b1;
          end else if (in_op == OP_MUL) begin
            load    = 1'b0;
            state_d = MUL_REQ;
          end else if (b_ext == '0) begin
            res_n = is_div ? '1 : a_ext;
          end else if (sgn && (a_ext == smin) && (&b_ext)) begin
            res_n = is_div ? a_ext : '0;
          end else begin
            load    = 1'b0;
            state_d = DIV_REQ;
          end
        end
        MUL_REQ: if (mul_ready) state_d = MUL_WAIT;
        MUL_WAIT: if (mul_out_valid) begin
          load    = 1'b1;
          res_n   = mul_res;
          state_d = DONE;
        end
        DIV_REQ: if (div_ready) state_d = DIV_WAIT;
        DIV_WAIT: if (div_out_valid) begin
          load    = 1'b1;
          res_n   = ((op_q == OP_DIV) || (op_q == OP_DIVU))
                    ? div_quot : div_rem;
          state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign cnt_d = (busy_q && busy_d) ? cnt_q + 1'b1 : '0;

  assign wsel = (state_q == IDLE) ? in_word : word_q;
  assign fin  = wsel ? {{(XLEN-32){res_n[31]}}, res_n[31:0]} : res_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      word_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      out_res_q <= '0;
      err_q     <= 1'b0;
      uflush_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      uflush_q <= uflush_d;
      err_q    <= err_q | err_set;
      if (load) out_res_q <= fin;
      if (take) begin
        op_q   <= in_op;
        word_q <= in_word;
        a_q    <= (in_op == OP_MUL) ? in_a : a_ext;
        b_q    <= (in_op == OP_MUL) ? in_b : b_ext;
      end
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign stall      = busy_q;
  assign out_valid  = (state_q == DONE);
  assign out_res    = out_res_q;
  assign err        = err_q;
  assign unit_flush = uflush_q;
  assign mul_valid  = (state_q == MUL_REQ);
  assign mul_a      = a_q;
  assign mul_b      = b_q;
  assign div_valid  = (state_q == DIV_REQ);
  assign div_signed = (op_q == OP_DIV) || (op_q == OP_REM);
  assign div_a      = a_q;
  assign div_b      = b_q;

endmodule
